axi_st_d256_tx_pkt_buffer: RTL and testbench
============================================

Name: axi_st_d256_tx_pkt_buffer

Overview:
Ingress packet buffer that sits directly upstream of the AXI-ST d256 gen1/gen2 master top. It accepts the application's AXI-Stream (256-bit data, 32-bit tkeep, tlast) and drives that block's user_t* inputs. It decouples application bursts from the logic-link credit flow and optionally runs store-and-forward, so a packet is only offered downstream once its last beat is buffered. It also checks tkeep legality and reports occupancy, packet count and a sticky error.

Parameters:
- DEPTH, 16: number of beat entries; must be a power of 2 and at least 2.
- DATA_W, 256: tdata width.
- KEEP_W, 32: tkeep width; equals DATA_W/8.

Ports:
- clk_wr  in  1  single clock.
- rst_wr  in  1  synchronous, active-high reset.
- tx_online  in  1  link online; gates out_tvalid.
- sf_mode  in  1  1 = store-and-forward, 0 = cut-through; change only when fifo_level==0.
- err_clr  in  1  clears err_keep.
- in_tdata  in  DATA_W  application data.
- in_tkeep  in  KEEP_W  application byte enables.
- in_tlast  in  1  application last beat.
- in_tvalid  in  1  application valid.
- in_tready  out  1  ready to the application.
- out_tdata  out  DATA_W  to master user_tdata.
- out_tkeep  out  KEEP_W  to master user_tkeep.
- out_tlast  out  1  to master user_tlast.
- out_tvalid  out  1  to master user_tvalid.
- out_tready  in  1  from master user_tready.
- fifo_level  out  $clog2(DEPTH+1)  entries held.
- pkt_count  out  $clog2(DEPTH+1)  complete packets held (tlast beats buffered).
- err_keep  out  1  sticky tkeep violation flag.

Behaviour:
- Entry is {tlast, tkeep, tdata}, 289 bits. This matches the master's 289-bit packing.
- Reset values while rst_wr=1 and on the cycle after: read/write pointers 0, fifo_level 0, pkt_count 0, err_keep 0, hold flag 0, out_tvalid 0, in_tready 0. Contents of out_tdata, out_tkeep and out_tlast are don't-care while out_tvalid=0.
- in_tready = !rst_wr && (fifo_level != DEPTH).
- push = in_tvalid & in_tready. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap).
- First-word fall-through: out_t* shows the entry at rd_ptr combinationally, with zero-cycle latency from a non-empty FIFO.
- Offer condition: offer = (fifo_level != 0) & tx_online & (!sf_mode | pkt_count != 0 | fifo_level == DEPTH).
  - The full term releases an oversized packet in store-and-forward mode (cut-through fallback) to avoid deadlock.
- out_tvalid = offer | hold.
- hold is set when out_tvalid & !out_tready and cleared on pop. This keeps AXI's rule that valid, once asserted, stays until accepted, even if tx_online drops or the offer condition changes.
- pop = out_tvalid & out_tready. rd_ptr increments modulo DEPTH.
- Minimum latency, empty FIFO to out_tvalid:
  - cut-through: 1 cycle after push.
  - store-and-forward: 1 cycle after the tlast push.
- fifo_level update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop when full is impossible, since in_tready=0.
  - Pop when empty is impossible, since out_tvalid=0.
- pkt_count: +1 on push with in_tlast, -1 on pop with out_tlast, unchanged when both happen in the same cycle. Never exceeds DEPTH.
- tkeep check on each push. Violation is either:
  - in_tlast=0 and in_tkeep != all-ones; or
  - in_tlast=1 and in_tkeep is zero or not of the form 2^n-1 (non-contiguous).
- On a violation err_keep is set the next cycle. The beat is still stored; data is never dropped.
- err_keep clears on err_clr. If a violation and err_clr occur in the same cycle, set wins.
- Throughput: 1 beat per cycle when both sides stream continuously.

Decomposition:
- Package axi_st_d256_pkg holds:
  - localparams ST_DATA_W=256, ST_KEEP_W=32, ST_ENTRY_W=289;
  - typedef struct packed st_entry_t {tlast, tkeep, tdata};
  - function keep_is_contiguous().
- One sub-module: axi_st_d256_tx_pkt_buffer_mem, a DEPTH x st_entry_t register array with synchronous write and asynchronous read. All pointer, level, hold and error logic stays in the top block.

Test Plan:
- Reset hold: keep rst_wr=1 for 3 cycles with in_tvalid=1 -> in_tready=0, out_tvalid=0, fifo_level=0 throughout. in_tready=1 on the 2nd cycle after release.
- Cut-through stream: sf_mode=0, tx_online=1, out_tready=1, push 100 beats back-to-back -> out_tvalid 1 cycle after the first push, data in order, fifo_level never above 1, zero bubbles.
- Store-and-forward: sf_mode=1, push a 4-beat packet with out_tready=1 -> out_tvalid stays 0 until the cycle after the tlast push. Then 4 pops in 4 cycles; pkt_count goes 0->1->0.
- Full and oversize packet: sf_mode=1, out_tready=0, push 16 beats with no tlast -> in_tready=0 at level 16 and out_tvalid=1 (full release). Raise out_tready -> all 16 beats drain, level returns to 0.
- Valid hold: out_tvalid=1 with out_tready=0, then drop tx_online -> out_tvalid stays 1 and out_tdata is stable until a pop occurs.
- tkeep errors: push a non-last beat with tkeep=0x7FFFFFFF -> err_keep=1 next cycle, beat still delivered. err_clr together with a last beat of tkeep=0x0000_00F0 -> err_keep stays 1. A later err_clr alone -> err_keep=0.

Source files
------------

// File: rtl/axi_st_d256_pkg.sv
// rtl/axi_st_d256_pkg.sv - shared widths, buffer entry layout and tkeep helper
package axi_st_d256_pkg;

  localparam int ST_DATA_W  = 256;
  localparam int ST_KEEP_W  = 32;
  localparam int ST_ENTRY_W = 1 + ST_KEEP_W + ST_DATA_W;

  typedef struct packed {
    logic                 tlast;
    logic [ST_KEEP_W-1:0] tkeep;
    logic [ST_DATA_W-1:0] tdata;
  } st_entry_t;

  // True only for a non-zero mask of the form 2^n-1 (low bytes valid, no holes).
  function automatic logic keep_is_contiguous(input logic [ST_KEEP_W-1:0] keep);
    return (keep != '0) && ((keep & (keep + ST_KEEP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/axi_st_d256_tx_pkt_buffer_mem.sv
// rtl/axi_st_d256_tx_pkt_buffer_mem.sv - beat storage, synchronous write, asynchronous read
module axi_st_d256_tx_pkt_buffer_mem
  import axi_st_d256_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [ST_ENTRY_W-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [ST_ENTRY_W-1:0] rd_data
);

  st_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= st_entry_t'(wr_data);
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi_st_d256_tx_pkt_buffer.sv
// rtl/axi_st_d256_tx_pkt_buffer.sv - ingress packet FIFO with cut-through / store-and-forward release
module axi_st_d256_tx_pkt_buffer
  import axi_st_d256_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = ST_DATA_W,
  parameter int KEEP_W = ST_KEEP_W
) (
  input  logic                       clk_wr,
  input  logic                       rst_wr,
  input  logic                       tx_online,
  input  logic                       sf_mode,
  input  logic                       err_clr,
  input  logic [DATA_W-1:0]          in_tdata,
  input  logic [KEEP_W-1:0]          in_tkeep,
  input  logic                       in_tlast,
  input  logic                       in_tvalid,
  output logic                       in_tready,
  output logic [DATA_W-1:0]          out_tdata,
  output logic [KEEP_W-1:0]          out_tkeep,
  output logic                       out_tlast,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count,
  output logic                       err_keep
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rst_q;
  logic          hold;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          offer;
  logic          keep_bad;
  st_entry_t     wr_entry;
  st_entry_t     rd_entry;
  logic [ST_ENTRY_W-1:0] rd_bits;

  assign full  = (fifo_level == LEVEL_FULL);
  assign empty = (fifo_level == '0);

  // rst_q keeps the input closed for one extra cycle after reset release.
  assign in_tready = !rst_wr && !rst_q && !full;
  assign push      = in_tvalid && in_tready;

  // Full buffer releases an oversized packet in store-and-forward mode.
  assign offer      = !empty && tx_online && (!sf_mode || (pkt_count != '0) || full);
  assign out_tvalid = !rst_wr && (offer || hold);
  assign pop        = out_tvalid && out_tready;

  assign keep_bad = in_tlast ? !keep_is_contiguous(in_tkeep) : (in_tkeep != '1);

  assign wr_entry.tlast = in_tlast;
  assign wr_entry.tkeep = in_tkeep;
  assign wr_entry.tdata = in_tdata;

  assign rd_entry  = st_entry_t'(rd_bits);
  assign out_tdata = rd_entry.tdata;
  assign out_tkeep = rd_entry.tkeep;
  assign out_tlast = rd_entry.tlast;

  axi_st_d256_tx_pkt_buffer_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk_wr),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_bits)
  );

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      rst_q      <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      pkt_count  <= '0;
      hold       <= 1'b0;
      err_keep   <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase

      case ({push && in_tlast, pop && rd_entry.tlast})
        2'b10:   pkt_count <= pkt_count + LW'(1);
        2'b01:   pkt_count <= pkt_count - LW'(1);
        default: pkt_count <= pkt_count;
      endcase

      // Once valid is shown it must stay until accepted, whatever the offer does.
      if (pop)                           hold <= 1'b0;
      else if (out_tvalid && !out_tready) hold <= 1'b1;

      if (push && keep_bad) err_keep <= 1'b1;
      else if (err_clr)     err_keep <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_st_d256_tx_pkt_buffer.sv
// tb/tb_axi_st_d256_tx_pkt_buffer.sv - self-checking bench with a queue-based reference model
module tb_axi_st_d256_tx_pkt_buffer;

  localparam int DEPTH = 16;

  logic         clk_wr = 1'b0;
  logic         rst_wr;
  logic         tx_online;
  logic         sf_mode;
  logic         err_clr;
  logic [255:0] in_tdata;
  logic [31:0]  in_tkeep;
  logic         in_tlast;
  logic         in_tvalid;
  logic         in_tready;
  logic [255:0] out_tdata;
  logic [31:0]  out_tkeep;
  logic         out_tlast;
  logic         out_tvalid;
  logic         out_tready;
  logic [4:0]   fifo_level;
  logic [4:0]   pkt_count;
  logic         err_keep;

  axi_st_d256_tx_pkt_buffer #(.DEPTH(DEPTH), .DATA_W(256), .KEEP_W(32)) dut (
    .clk_wr     (clk_wr),
    .rst_wr     (rst_wr),
    .tx_online  (tx_online),
    .sf_mode    (sf_mode),
    .err_clr    (err_clr),
    .in_tdata   (in_tdata),
    .in_tkeep   (in_tkeep),
    .in_tlast   (in_tlast),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .fifo_level (fifo_level),
    .pkt_count  (pkt_count),
    .err_keep   (err_keep)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct {
    logic         last;
    logic [31:0]  keep;
    logic [255:0] data;
  } beat_t;

  beat_t q[$];
  int    m_pkts;
  bit    m_err;
  bit    m_pending;
  bit    m_rst_prev;
  int    pops;
  bit    last_push;
  int    vectors;
  int    miscompares;

  logic         exp_ready;
  logic         exp_valid;
  logic [4:0]   exp_level;
  logic [4:0]   exp_pkts;
  logic         exp_err;
  logic [288:0] exp_head;

  function automatic logic [255:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit keep_illegal(logic [31:0] k, logic last);
    if (!last) return k != 32'hFFFF_FFFF;
    for (int n = 1; n <= 32; n++)
      if ({32'd0, k} == ((64'd1 << n) - 64'd1)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] rand_keep(logic last);
    int sel;
    int n;
    sel = $urandom_range(0, 5);
    if (sel == 0) return 32'($urandom);
    if (!last || sel < 3) return 32'hFFFF_FFFF;
    n = $urandom_range(1, 32);
    return 32'((64'd1 << n) - 64'd1);
  endfunction

  // Expected outputs for the current inputs, from the model state.
  task automatic predict();
    exp_level = 5'(q.size());
    exp_pkts  = 5'(m_pkts);
    exp_err   = m_err;
    exp_ready = !rst_wr && !m_rst_prev && (q.size() != DEPTH);
    exp_valid = !rst_wr && (m_pending ||
                ((q.size() != 0) && tx_online && (!sf_mode || m_pkts != 0 || q.size() == DEPTH)));
    exp_head  = (q.size() != 0) ? {q[0].last, q[0].keep, q[0].data} : '0;
  endtask

  task automatic tick();
    bit    do_push;
    bit    do_pop;
    beat_t b;
    predict();
    do_push = in_tvalid && exp_ready;
    do_pop  = exp_valid && out_tready;
    last_push = do_push;
    if (rst_wr) begin
      q.delete();
      m_pkts = 0;
      m_err = 1'b0;
      m_pending = 1'b0;
    end else begin
      if (do_pop) begin
        if (q[0].last) m_pkts--;
        void'(q.pop_front());
        pops++;
      end
      if (do_push) begin
        b.last = in_tlast;
        b.keep = in_tkeep;
        b.data = in_tdata;
        q.push_back(b);
        if (in_tlast) m_pkts++;
      end
      if (do_push && keep_illegal(in_tkeep, in_tlast)) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_pending = exp_valid && !do_pop;
    end
    m_rst_prev = rst_wr;
    @(posedge clk_wr);
    #1;
  endtask

  task automatic test_reset();
    rst_wr = 1'b1;
    in_tvalid = 1'b1;
    in_tdata = rand_data();
    in_tkeep = 32'hFFFF_FFFF;
    in_tlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (in_tready !== 1'b0) begin miscompares++; $display("FAIL reset_in_tready cyc%0d got %b exp 0", i, in_tready); end
      vectors++;
      if (out_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_out_tvalid cyc%0d got %b exp 0", i, out_tvalid); end
      vectors++;
      if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL reset_level cyc%0d got %0d exp 0", i, fifo_level); end
      tick();
    end
    rst_wr = 1'b0;
    in_tvalid = 1'b0;
    #1;
    vectors++;
    if (in_tready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_rel1 got %b exp 0", in_tready); end
    vectors++;
    if ({pkt_count, err_keep, out_tvalid} !== 7'd0) begin
      miscompares++; $display("FAIL reset_regs got pkt=%0d err=%b v=%b exp 0", pkt_count, err_keep, out_tvalid);
    end
    tick();
    #1;
    vectors++;
    if (in_tready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_rel2 got %b exp 1", in_tready); end
    tick();
  endtask

  task automatic test_cut_through();
    sf_mode = 1'b0; tx_online = 1'b1; out_tready = 1'b1; err_clr = 1'b0;
    pops = 0;
    for (int i = 0; i <= 100; i++) begin
      in_tvalid = (i < 100);
      in_tdata  = rand_data();
      in_tkeep  = 32'hFFFF_FFFF;
      in_tlast  = 1'($urandom_range(0, 1));
      #1;
      predict();
      vectors++;
      if (out_tvalid !== (i != 0)) begin miscompares++; $display("FAIL ct_valid cyc%0d got %b exp %b", i, out_tvalid, i != 0); end
      if (i != 0) begin
        vectors++;
        if ({out_tlast, out_tkeep, out_tdata} !== exp_head) begin
          miscompares++; $display("FAIL ct_data cyc%0d got %h exp %h", i, out_tdata, exp_head[255:0]);
        end
      end
      vectors++;
      if (fifo_level > 5'd1) begin miscompares++; $display("FAIL ct_level cyc%0d got %0d exp <=1", i, fifo_level); end
      tick();
    end
    vectors++;
    if (pops != 100) begin miscompares++; $display("FAIL ct_pops got %0d exp 100", pops); end
  endtask

  task automatic test_store_forward();
    sf_mode = 1'b1; tx_online = 1'b1; out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_tvalid = 1'b1;
      in_tdata  = rand_data();
      in_tkeep  = 32'hFFFF_FFFF;
      in_tlast  = (i == 3);
      #1;
      vectors++;
      if (out_tvalid !== 1'b0) begin miscompares++; $display("FAIL sf_early_valid beat%0d got %b exp 0", i, out_tvalid); end
      vectors++;
      if (pkt_count !== 5'd0) begin miscompares++; $display("FAIL sf_pkt_fill beat%0d got %0d exp 0", i, pkt_count); end
      tick();
    end
    in_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      predict();
      vectors++;
      if (out_tvalid !== 1'b1) begin miscompares++; $display("FAIL sf_drain_valid pop%0d got %b exp 1", i, out_tvalid); end
      vectors++;
      if (pkt_count !== 5'd1) begin miscompares++; $display("FAIL sf_pkt_drain pop%0d got %0d exp 1", i, pkt_count); end
      vectors++;
      if ({out_tlast, out_tkeep, out_tdata} !== exp_head) begin
        miscompares++; $display("FAIL sf_data pop%0d got %h exp %h", i, out_tdata, exp_head[255:0]);
      end
      tick();
    end
    #1;
    vectors++;
    if ({pkt_count, fifo_level, out_tvalid} !== 11'd0) begin
      miscompares++; $display("FAIL sf_end got pkt=%0d lvl=%0d v=%b exp 0/0/0", pkt_count, fifo_level, out_tvalid);
    end
  endtask

  task automatic test_full_oversize();
    int guard;
    sf_mode = 1'b1; tx_online = 1'b1; out_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_tvalid = 1'b1;
      in_tdata  = rand_data();
      in_tkeep  = 32'hFFFF_FFFF;
      in_tlast  = 1'b0;
      #1;
      vectors++;
      if ({in_tready, out_tvalid} !== 2'b10) begin
        miscompares++; $display("FAIL full_fill beat%0d got rdy=%b v=%b exp 1/0", i, in_tready, out_tvalid);
      end
      tick();
    end
    in_tvalid = 1'b0;
    #1;
    vectors++;
    if ({fifo_level, in_tready, out_tvalid} !== {5'd16, 2'b01}) begin
      miscompares++; $display("FAIL full_state got lvl=%0d rdy=%b v=%b exp 16/0/1", fifo_level, in_tready, out_tvalid);
    end
    tick();
    out_tready = 1'b1;
    in_tvalid = 1'b1;
    in_tdata  = rand_data();
    in_tlast  = 1'b1;
    pops = 0;
    guard = 0;
    while ((q.size() != 0 || in_tvalid) && guard < 60) begin
      #1;
      predict();
      vectors++;
      if (out_tvalid !== exp_valid) begin miscompares++; $display("FAIL full_drain_valid cyc%0d got %b exp %b", guard, out_tvalid, exp_valid); end
      if (exp_valid) begin
        vectors++;
        if ({out_tlast, out_tkeep, out_tdata} !== exp_head) begin
          miscompares++; $display("FAIL full_drain_data cyc%0d got %h exp %h", guard, out_tdata, exp_head[255:0]);
        end
      end
      tick();
      if (last_push) in_tvalid = 1'b0;
      guard++;
    end
    #1;
    vectors++;
    if (guard >= 60 || fifo_level !== 5'd0 || pops != 17) begin
      miscompares++; $display("FAIL full_drain_end got lvl=%0d pops=%0d cyc=%0d exp 0/17", fifo_level, pops, guard);
    end
  endtask

  task automatic test_valid_hold();
    logic [255:0] d;
    sf_mode = 1'b0; tx_online = 1'b1; out_tready = 1'b0;
    d = rand_data();
    in_tvalid = 1'b1; in_tdata = d; in_tkeep = 32'hFFFF_FFFF; in_tlast = 1'b1;
    tick();
    in_tvalid = 1'b0;
    in_tdata = rand_data();
    tick();
    tx_online = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (out_tvalid !== 1'b1) begin miscompares++; $display("FAIL hold_valid cyc%0d got %b exp 1", i, out_tvalid); end
      vectors++;
      if (out_tdata !== d) begin miscompares++; $display("FAIL hold_data cyc%0d got %h exp %h", i, out_tdata, d); end
      tick();
    end
    out_tready = 1'b1;
    tick();
    #1;
    vectors++;
    if ({out_tvalid, fifo_level} !== 6'd0) begin
      miscompares++; $display("FAIL hold_release got v=%b lvl=%0d exp 0/0", out_tvalid, fifo_level);
    end
    tx_online = 1'b1;
  endtask

  task automatic test_keep_errors();
    sf_mode = 1'b0; tx_online = 1'b1; out_tready = 1'b1; err_clr = 1'b0;
    in_tvalid = 1'b1; in_tdata = rand_data(); in_tkeep = 32'h7FFF_FFFF; in_tlast = 1'b0;
    #1;
    vectors++;
    if (err_keep !== 1'b0) begin miscompares++; $display("FAIL keep_pre got %b exp 0", err_keep); end
    tick();
    in_tkeep = 32'h0000_00F0; in_tlast = 1'b1; err_clr = 1'b1;
    #1;
    vectors++;
    if (err_keep !== 1'b1) begin miscompares++; $display("FAIL keep_set got %b exp 1", err_keep); end
    vectors++;
    if ({out_tvalid, out_tkeep} !== {1'b1, 32'h7FFF_FFFF}) begin
      miscompares++; $display("FAIL keep_delivered got v=%b k=%h exp 1/7fffffff", out_tvalid, out_tkeep);
    end
    tick();
    in_tvalid = 1'b0; err_clr = 1'b0;
    #1;
    vectors++;
    if (err_keep !== 1'b1) begin miscompares++; $display("FAIL keep_set_wins got %b exp 1", err_keep); end
    vectors++;
    if ({out_tvalid, out_tlast, out_tkeep} !== {2'b11, 32'h0000_00F0}) begin
      miscompares++; $display("FAIL keep_last_delivered got v=%b l=%b k=%h exp 1/1/000000f0", out_tvalid, out_tlast, out_tkeep);
    end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    in_tvalid = 1'b1; in_tkeep = 32'h0000_FFFF; in_tlast = 1'b1;
    #1;
    vectors++;
    if (err_keep !== 1'b0) begin miscompares++; $display("FAIL keep_clear got %b exp 0", err_keep); end
    tick();
    in_tkeep = 32'h0;
    #1;
    vectors++;
    if (err_keep !== 1'b0) begin miscompares++; $display("FAIL keep_legal_last got %b exp 0", err_keep); end
    tick();
    in_tvalid = 1'b0;
    #1;
    vectors++;
    if (err_keep !== 1'b1) begin miscompares++; $display("FAIL keep_zero_last got %b exp 1", err_keep); end
    err_clr = 1'b1;
    tick();
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if (q.size() == 0 && $urandom_range(0, 9) == 0) sf_mode = ~sf_mode;
      in_tvalid  = ($urandom_range(0, 3) != 0);
      in_tdata   = rand_data();
      in_tlast   = ($urandom_range(0, 3) == 0);
      in_tkeep   = rand_keep(in_tlast);
      out_tready = ($urandom_range(0, 9) < 7);
      tx_online  = ($urandom_range(0, 9) != 0);
      err_clr    = ($urandom_range(0, 9) == 0);
      #1;
      predict();
      vectors++;
      if (in_tready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready cyc%0d got %b exp %b", i, in_tready, exp_ready); end
      vectors++;
      if (out_tvalid !== exp_valid) begin miscompares++; $display("FAIL rnd_valid cyc%0d got %b exp %b", i, out_tvalid, exp_valid); end
      vectors++;
      if (fifo_level !== exp_level) begin miscompares++; $display("FAIL rnd_level cyc%0d got %0d exp %0d", i, fifo_level, exp_level); end
      vectors++;
      if (pkt_count !== exp_pkts) begin miscompares++; $display("FAIL rnd_pkts cyc%0d got %0d exp %0d", i, pkt_count, exp_pkts); end
      vectors++;
      if (err_keep !== exp_err) begin miscompares++; $display("FAIL rnd_err cyc%0d got %b exp %b", i, err_keep, exp_err); end
      if (exp_valid) begin
        vectors++;
        if ({out_tlast, out_tkeep, out_tdata} !== exp_head) begin
          miscompares++; $display("FAIL rnd_data cyc%0d got %b/%h/%h exp %h", i, out_tlast, out_tkeep, out_tdata[31:0], exp_head[288:256]);
        end
      end
      tick();
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_pkts = 0; m_err = 1'b0; m_pending = 1'b0; m_rst_prev = 1'b1; pops = 0; last_push = 1'b0;
    rst_wr = 1'b1; tx_online = 1'b0; sf_mode = 1'b0; err_clr = 1'b0;
    in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0; in_tvalid = 1'b0; out_tready = 1'b0;
    @(posedge clk_wr);
    #1;
    test_reset();
    test_cut_through();
    test_store_forward();
    test_full_oversize();
    test_valid_hold();
    test_keep_errors();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
